riscv_data_bridge: RTL and testbench

Data-side bus bridge directly downstream of the RISC-V core's load/store stage. Converts the core's single-cycle load/store request into a valid/ready transaction on the memory bus with byte enables, stalls the core until the transaction completes, and returns right-justified read data. Also flags misaligned accesses and bus timeouts so loads and stores with variable-latency memory never hang the pipeline.

---
 rtl/riscv_data_bridge.sv | 152 +++++++++++++++
 tb/tb_riscv_data_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_bridge.sv
// riscv_data_bridge: turns load/store stage requests into valid/ready bus
// transactions with byte lanes, read alignment and error/timeout reporting.
module riscv_data_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] core_address,
   input  logic [1:0]  core_width,
   input  logic [31:0] core_wdata,
   input  logic        core_read,
   input  logic        core_write,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   output logic        core_error,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_write,
   output logic [31:0] bus_address,
   output logic [3:0]  bus_byte_enable,
   output logic [31:0] bus_wdata,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

   state_t      state_q;
   logic        valid_q;
   logic        write_q;
   logic        error_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [3:0]  be_q;
   logic [1:0]  off_q;
   logic [1:0]  width_q;
   logic [15:0] cnt_q;

   logic        req;
   logic        illegal;
   logic        last;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [31:0] rdata_d;

   assign req  = core_read | core_write;
   assign last = (cnt_q == 16'(TIMEOUT - 1));

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = core_wdata;
      illegal = core_read & core_write;
      unique case (core_width)
         2'd0: begin
            be_d    = 4'b0001 << core_address[1:0];
            wdata_d = {4{core_wdata[7:0]}};
         end
         2'd1: begin
            be_d    = core_address[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{core_wdata[15:0]}};
            illegal = illegal | core_address[0];
         end
         2'd2: illegal = illegal | (|core_address[1:0]);
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      unique case (width_q)
         2'd0: rdata_d = (bus_rdata >> {off_q, 3'b000}) & 32'h0000_00FF;
         2'd1: rdata_d = (bus_rdata >> {off_q[1], 4'b0000}) & 32'h0000_FFFF;
         default: rdata_d = bus_rdata;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         write_q <= 1'b0;
         error_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
         off_q   <= '0;
         width_q <= '0;
         cnt_q   <= '0;
      end else begin
         error_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req && illegal) begin
                  state_q <= DONE;
                  error_q <= 1'b1;
               end else if (req) begin
                  state_q <= REQ;
                  valid_q <= 1'b1;
                  write_q <= core_write;
                  addr_q  <= {core_address[31:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
                  off_q   <= core_address[1:0];
                  width_q <= core_width;
                  cnt_q   <= '0;
               end
            end
            REQ: begin
               cnt_q <= cnt_q + 16'd1;
               if (bus_ready && write_q) begin
                  state_q <= DONE;
                  valid_q <= 1'b0;
               end else if (last) begin
                  // A load accepted on its final cycle still has no data.
                  state_q <= DONE;
                  valid_q <= 1'b0;
                  error_q <= 1'b1;
                  if (!write_q) rdata_q <= '0;
               end else if (bus_ready) begin
                  state_q <= WAIT_RESP;
                  valid_q <= 1'b0;
               end
            end
            WAIT_RESP: begin
               cnt_q <= cnt_q + 16'd1;
               if (bus_rvalid) begin
                  state_q <= DONE;
                  rdata_q <= rdata_d;
               end else if (last) begin
                  state_q <= DONE;
                  error_q <= 1'b1;
                  rdata_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign core_stall = ~reset & ((state_q == IDLE && req) ||
                                 state_q == REQ || state_q == WAIT_RESP);

   assign core_rdata      = rdata_q;
   assign core_error      = error_q;
   assign bus_valid       = valid_q;
   assign bus_write       = write_q;
   assign bus_address     = addr_q;
   assign bus_byte_enable = be_q;
   assign bus_wdata       = wdata_q;

endmodule

// File: tb/tb_riscv_data_bridge.sv
// tb_riscv_data_bridge: scoreboard bench driving core accesses against a
// small bus responder and comparing each completed access to its model.
module tb_riscv_data_bridge;

   localparam int TO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] core_address;
   logic [1:0]  core_width;
   logic [31:0] core_wdata;
   logic        core_read;
   logic        core_write;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        core_error;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_write;
   logic [31:0] bus_address;
   logic [3:0]  bus_byte_enable;
   logic [31:0] bus_wdata;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   riscv_data_bridge #(.TIMEOUT(TO)) dut (
      .clock(clock),
      .reset(reset),
      .core_address(core_address),
      .core_width(core_width),
      .core_wdata(core_wdata),
      .core_read(core_read),
      .core_write(core_write),
      .core_rdata(core_rdata),
      .core_stall(core_stall),
      .core_error(core_error),
      .bus_valid(bus_valid),
      .bus_ready(bus_ready),
      .bus_write(bus_write),
      .bus_address(bus_address),
      .bus_byte_enable(bus_byte_enable),
      .bus_wdata(bus_wdata),
      .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
      logic        err;
      int          stalls;
      int          vcyc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] model_rd = '0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic access(input logic [31:0] a, input logic [1:0] w,
                         input logic [31:0] wd, input logic rd,
                         input logic wr, input int rdy_wait,
                         input logic [31:0] rdat);
      exp_t        e;
      exp_t        g;
      logic        ill;
      logic [31:0] al;
      logic [31:0] sa = '0;
      logic [31:0] swd = '0;
      logic [3:0]  sbe = '0;
      logic        swe = 1'b0;
      int          stalls = 0;
      int          vcyc = 0;
      bit          rvp = 0;
      bit          done = 0;

      ill = (rd && wr) || w == 2'd3 || (w == 2'd1 && a[0]) ||
            (w == 2'd2 && a[1:0] != 2'b00);
      e.addr = {a[31:2], 2'b00};
      e.we   = wr;
      case (w)
         2'd0: begin
            e.be    = 4'b0001 << a[1:0];
            e.wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            al      = (rdat >> (8 * a[1:0])) & 32'hFF;
         end
         2'd1: begin
            e.be    = a[1] ? 4'b1100 : 4'b0011;
            e.wdata = {wd[15:0], wd[15:0]};
            al      = (rdat >> (16 * a[1])) & 32'hFFFF;
         end
         default: begin
            e.be    = 4'b1111;
            e.wdata = wd;
            al      = rdat;
         end
      endcase
      if (ill) begin
         e.err = 1; e.stalls = 1; e.vcyc = 0; e.rdata = model_rd;
      end else if (rdy_wait < 0) begin
         e.err = 1; e.stalls = TO + 1; e.vcyc = TO;
         e.rdata = rd ? 32'h0 : model_rd;
      end else begin
         e.err = 0; e.vcyc = rdy_wait + 1;
         e.stalls = wr ? rdy_wait + 2 : rdy_wait + 3;
         e.rdata = rd ? al : model_rd;
      end
      model_rd = e.rdata;
      sb.push_back(e);

      core_address = a;
      core_width   = w;
      core_wdata   = wd;
      core_read    = rd;
      core_write   = wr;
      #1;
      for (int c = 0; c < 40 && !done; c++) begin
         bus_ready  = 1'b0;
         bus_rvalid = 1'b0;
         bus_rdata  = $urandom;
         if (!core_stall) begin
            done = 1;
         end else begin
            stalls++;
            if (rvp) begin
               bus_rvalid = 1'b1;
               bus_rdata  = rdat;
               rvp        = 0;
            end
            if (bus_valid) begin
               vcyc++;
               sa  = bus_address;
               sbe = bus_byte_enable;
               swd = bus_wdata;
               swe = bus_write;
               if (rdy_wait >= 0 && vcyc > rdy_wait) begin
                  bus_ready  = 1'b1;
                  bus_rvalid = 1'b1;
                  bus_rdata  = 32'hBAD0_BAD0;
                  rvp        = !wr;
               end
            end
         end
         if (done) begin
            g = sb.pop_front();
            check("done_error", {31'h0, core_error}, {31'h0, g.err});
            check("done_rdata", core_rdata, g.rdata);
            check("stall_cycles", stalls, g.stalls);
            check("valid_cycles", vcyc, g.vcyc);
            check("done_valid", {31'h0, bus_valid}, 32'h0);
            if (g.vcyc > 0) begin
               check("bus_address", sa, g.addr);
               check("byte_enable", {28'h0, sbe}, {28'h0, g.be});
               check("bus_write", {31'h0, swe}, {31'h0, g.we});
               if (g.we) check("bus_wdata", swd, g.wdata);
            end
            core_read  = 1'b0;
            core_write = 1'b0;
         end
         @(posedge clock);
         #2;
      end
      if (!done) check("access_bound", 32'h0, 32'h1);
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hFEED_F00D;
      #1;
      check("after_error", {31'h0, core_error}, 32'h0);
      check("after_rdata", core_rdata, model_rd);
      check("after_stall", {31'h0, core_stall}, 32'h0);
      @(posedge clock);
      #2;
      bus_rvalid = 1'b0;
      check("late_rvalid", core_rdata, model_rd);
   endtask

   task automatic reset_mid_load();
      core_address = 32'h0000_0100;
      core_width   = 2'd2;
      core_read    = 1'b1;
      core_write   = 1'b0;
      @(posedge clock);
      #2;
      bus_ready = 1'b1;
      check("rst_req_valid", {31'h0, bus_valid}, 32'h1);
      @(posedge clock);
      #2;
      bus_ready = 1'b0;
      check("rst_wait_stall", {31'h0, core_stall}, 32'h1);
      reset = 1'b1;
      @(posedge clock);
      #2;
      check("rst_stall_low", {31'h0, core_stall}, 32'h0);
      reset      = 1'b0;
      core_read  = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h1234_5678;
      @(posedge clock);
      #2;
      bus_rvalid = 1'b0;
      model_rd   = '0;
      check("rst_rdata", core_rdata, 32'h0);
      check("rst_valid", {31'h0, bus_valid}, 32'h0);
      check("rst_address", bus_address, 32'h0);
      check("rst_be", {28'h0, bus_byte_enable}, 32'h0);
      check("rst_wdata", bus_wdata, 32'h0);
      check("rst_write", {31'h0, bus_write}, 32'h0);
      check("rst_error", {31'h0, core_error}, 32'h0);
   endtask

   initial begin
      reset        = 1'b1;
      core_address = 32'h0000_0100;
      core_width   = 2'd2;
      core_wdata   = '0;
      core_read    = 1'b1;
      core_write   = 1'b0;
      bus_ready    = 1'b0;
      bus_rvalid   = 1'b0;
      bus_rdata    = '0;
      repeat (3) @(posedge clock);
      #2;
      check("init_stall", {31'h0, core_stall}, 32'h0);
      check("init_valid", {31'h0, bus_valid}, 32'h0);
      check("init_rdata", core_rdata, 32'h0);
      check("init_error", {31'h0, core_error}, 32'h0);
      check("init_be", {28'h0, bus_byte_enable}, 32'h0);
      core_read = 1'b0;
      reset     = 1'b0;
      @(posedge clock);
      #2;

      access(32'h0000_0100, 2'd2, 32'h0, 1, 0, 0, 32'hDEAD_BEEF);
      access(32'h0000_0103, 2'd0, 32'h0, 1, 0, 0, 32'hAABB_CCDD);
      access(32'h0000_0102, 2'd1, 32'h0, 1, 0, 0, 32'hAABB_CCDD);
      access(32'h0000_0202, 2'd1, 32'h1234, 0, 1, 2, 32'h0);
      access(32'h0000_0101, 2'd2, 32'h0, 1, 0, 0, 32'h1111_1111);
      access(32'h0000_0003, 2'd1, 32'h5555, 0, 1, 0, 32'h0);
      access(32'h0000_0000, 2'd3, 32'h0, 1, 0, 0, 32'h2222_2222);
      access(32'h0000_0010, 2'd2, 32'h7, 1, 1, 0, 32'h3333_3333);
      access(32'h0000_0001, 2'd0, 32'h0000_005A, 0, 1, 0, 32'h0);
      access(32'h0000_0400, 2'd2, 32'hCAFE_0001, 0, 1, 1, 32'h0);
      access(32'h0000_0041, 2'd0, 32'h0, 1, 0, 1, 32'h8877_6655);
      access(32'h0000_0040, 2'd1, 32'h0, 1, 0, 0, 32'h8877_6655);
      reset_mid_load();
      access(32'h0000_0044, 2'd2, 32'h0, 1, 0, 2, 32'h0BAD_CAFE);
      access(32'h0000_0080, 2'd2, 32'h0, 1, 0, -1, 32'h0);
      access(32'h0000_0084, 2'd2, 32'h9999, 0, 1, -1, 32'h0);

      if (sb.size() != 0) check("sb_empty", sb.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
